// File: rtl/misalign_splitter.sv
// Misaligned-access splitter between the MEM stage and the load/store buffer.
// Aligned requests pass through combinationally. A misaligned load becomes two
// aligned word loads whose data is merged, shifted and extended here. A
// misaligned store becomes a series of byte stores. Only one downstream
// transaction is ever outstanding.
module misalign_splitter #(
  parameter int unsigned XLEN             = 32,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            up_valid_i,
  input  logic [XLEN-1:0] up_addr_i,
  input  logic            up_rw_i,
  input  logic [1:0]      up_size_i,
  input  logic [XLEN-1:0] up_data_i,
  input  logic            up_sign_i,
  output logic            up_ready_o,
  output logic            up_rsp_valid_o,
  output logic [XLEN-1:0] up_rsp_data_o,
  output logic            misalign_fault_o,
  output logic            down_valid_o,
  output logic [XLEN-1:0] down_addr_o,
  output logic            down_rw_o,
  output logic [1:0]      down_size_o,
  output logic [XLEN-1:0] down_data_o,
  output logic            down_sign_o,
  input  logic            down_ready_i,
  input  logic            down_rsp_valid_i,
  input  logic [XLEN-1:0] down_rsp_data_i
);

  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;
  localparam logic [1:0] SZ_WORD = 2'd3;

  typedef enum logic [2:0] {
    IDLE, LD_LO, WT_LO, LD_HI, WT_HI, ST_ISS, ST_WT, DRAIN
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [1:0]      size_q, size_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            sign_q, sign_d;
  logic            rw_q, rw_d;

  logic            up_misaligned;
  logic [XLEN-1:0] base_addr;
  logic [XLEN-1:0] merged_word;
  logic [XLEN-1:0] load_result;
  logic [7:0]      store_byte;
  logic [1:0]      last_cnt;

  // Datapath helpers: misalignment detect, word merge/extend, store byte select.
  always_comb begin
    up_misaligned = ((up_size_i == SZ_HALF) && up_addr_i[0]) ||
                    ((up_size_i == SZ_WORD) && (up_addr_i[1:0] != 2'b00));
    base_addr     = {addr_q[XLEN-1:2], 2'b00};
    merged_word   = XLEN'({down_rsp_data_i, lo_q} >> {addr_q[1:0], 3'b000});
    if (size_q == SZ_HALF) begin
      load_result = {{(XLEN-16){sign_q & merged_word[15]}}, merged_word[15:0]};
    end else begin
      load_result = merged_word;
    end
    store_byte = 8'(data_q >> {cnt_q, 3'b000});
    last_cnt   = (size_q == SZ_HALF) ? 2'd1 : 2'd3;
  end

  // Next-state and output logic; outputs are forced low while reset is asserted.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    state_d          = state_q;
    addr_d           = addr_q;
    data_d           = data_q;
    lo_d             = lo_q;
    size_d           = size_q;
    cnt_d            = cnt_q;
    sign_d           = sign_q;
    rw_d             = rw_q;
    up_ready_o       = 1'b0;
    up_rsp_valid_o   = 1'b0;
    up_rsp_data_o    = '0;
    misalign_fault_o = 1'b0;
    down_valid_o     = 1'b0;
    down_addr_o      = '0;
    down_rw_o        = 1'b0;
    down_size_o      = 2'b00;
    down_data_o      = '0;
    down_sign_o      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (up_valid_i && up_misaligned) begin
          // A misaligned request during a flush is simply not taken.
          if (!flush_i) begin
            up_ready_o = 1'b1;
            if (ALLOW_MISALIGNED) begin
              addr_d  = up_addr_i;
              data_d  = up_data_i;
              size_d  = up_size_i;
              sign_d  = up_sign_i;
              rw_d    = up_rw_i;
              cnt_d   = 2'd0;
              state_d = up_rw_i ? ST_ISS : LD_LO;
            end else begin
              misalign_fault_o = 1'b1;
            end
          end
        end else begin
          down_valid_o   = up_valid_i;
          down_addr_o    = up_addr_i;
          down_rw_o      = up_rw_i;
          down_size_o    = up_size_i;
          down_data_o    = up_data_i;
          down_sign_o    = up_sign_i;
          up_ready_o     = down_ready_i;
          up_rsp_valid_o = down_rsp_valid_i && !flush_i;
          up_rsp_data_o  = down_rsp_data_i;
          // A request that slips out with the flush still owes a response.
          if (flush_i && up_valid_i && down_ready_i) state_d = DRAIN;
        end
      end

      LD_LO, LD_HI: begin
        down_valid_o = 1'b1;
        down_addr_o  = (state_q == LD_LO) ? base_addr : base_addr + XLEN'(4);
        down_size_o  = SZ_WORD;
        if (down_ready_i) begin
          if (flush_i)                state_d = DRAIN;
          else if (state_q == LD_LO)  state_d = WT_LO;
          else                        state_d = WT_HI;
        end else if (flush_i) begin
          state_d = IDLE;
        end
      end

      WT_LO: begin
        if (flush_i) begin
          state_d = down_rsp_valid_i ? IDLE : DRAIN;
        end else if (down_rsp_valid_i) begin
          lo_d    = down_rsp_data_i;
          state_d = LD_HI;
        end
      end

      WT_HI: begin
        if (flush_i) begin
          state_d = down_rsp_valid_i ? IDLE : DRAIN;
        end else if (down_rsp_valid_i) begin
          up_rsp_valid_o = 1'b1;
          up_rsp_data_o  = load_result;
          state_d        = IDLE;
        end
      end

      ST_ISS: begin
        down_valid_o = 1'b1;
        down_addr_o  = addr_q + XLEN'(cnt_q);
        down_rw_o    = rw_q;
        down_size_o  = SZ_BYTE;
        down_data_o  = XLEN'(store_byte);
        if (down_ready_i) begin
          state_d = flush_i ? DRAIN : ST_WT;
        end else if (flush_i) begin
          state_d = IDLE;
        end
      end

      ST_WT: begin
        if (flush_i) begin
          state_d = down_rsp_valid_i ? IDLE : DRAIN;
        end else if (down_rsp_valid_i) begin
          if (cnt_q == last_cnt) begin
            up_rsp_valid_o = 1'b1;
            state_d        = IDLE;
          end else begin
            cnt_d   = cnt_q + 2'd1;
            state_d = ST_ISS;
          end
        end
      end

      DRAIN: begin
        if (down_rsp_valid_i) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (!rst_ni) begin
      up_ready_o       = 1'b0;
      up_rsp_valid_o   = 1'b0;
      up_rsp_data_o    = '0;
      misalign_fault_o = 1'b0;
      down_valid_o     = 1'b0;
      down_addr_o      = '0;
      down_rw_o        = 1'b0;
      down_size_o      = 2'b00;
      down_data_o      = '0;
      down_sign_o      = 1'b0;
    end
  end

  // State and latched-request registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      lo_q    <= '0;
      size_q  <= 2'b00;
      cnt_q   <= 2'd0;
      sign_q  <= 1'b0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      lo_q    <= lo_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      rw_q    <= rw_d;
    end
  end

endmodule
